// File: rtl/times_table_writer_pkg.sv
// Shared definitions for the times-table writer: default widths, table size
// and the FSM state encoding used by the writer's control path.
package times_table_writer_pkg;

    localparam int DEF_OP_W       = 3;
    localparam int DEF_ADDR_W     = 2 * DEF_OP_W;
    localparam int DEF_PROD_W     = 2 * DEF_OP_W;
    localparam int DEF_TABLE_SIZE = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/times_table_writer_shift_add_mul.sv
// Iterative unsigned shift-add multiplier. A load captures the operands; the
// following OP_W cycles each examine one multiplier bit, LSB first. In the
// last of those cycles valid is high and product presents the finished result.
module shift_add_mul
    import times_table_writer_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int PROD_W = 2 * OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product,
    output logic              valid
);

    localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] partial;
    logic [OP_W-1:0]   mplier;
    logic [CNT_W-1:0]  step;
    logic              run;

    // The multiplicand already sits at the current bit's weight, so the
    // running sum plus this cycle's partial product is the result so far.
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign valid   = run && (step == CNT_W'(OP_W - 1));

    // Operand capture on load, then one shift-add step per cycle while running.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            step   <= '0;
            run    <= 1'b0;
        end else if (load) begin
            mcand  <= PROD_W'(a);
            acc    <= '0;
            mplier <= b;
            step   <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + CNT_W'(1);
            if (valid) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/times_table_writer.sv
// Times-table writer: on start, walks every (a,b) operand pair, multiplies
// them with shift_add_mul and writes a*b to address {a,b} of the table RAM
// over a valid/ready write port, then pulses done.
// Optional build macro CHECKSUM_EN adds a running sum of accepted write data
// on the checksum output.
module times_table_writer
    import times_table_writer_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int ADDR_W = 2 * OP_W,
    parameter int PROD_W = 2 * OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PROD_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [PROD_W+ADDR_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] load_index;
    logic              load;
    logic              mul_valid;
    logic [PROD_W-1:0] product;

    // The multiplier is loaded with the entry that is about to be computed,
    // which is why it sees load_index rather than the registered index.
    shift_add_mul #(
        .OP_W   (OP_W),
        .PROD_W (PROD_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .a       (load_index[ADDR_W-1:OP_W]),
        .b       (load_index[OP_W-1:0]),
        .product (product),
        .valid   (mul_valid)
    );

    // Next-state, multiplier load and Moore outputs of the fill sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        load       = 1'b0;
        load_index = index;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                    load       = 1'b1;
                    load_index = '0;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (mul_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                        load       = 1'b1;
                        load_index = index + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry index and the write payload, which stays frozen through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            index   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (load) begin
                index <= load_index;
            end
            if (state == CALC && mul_valid) begin
                wr_addr <= index;
                wr_data <= product;
            end
        end
    end

`ifdef CHECKSUM_EN
    // Running sum of accepted write data; restarts with each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (wr_en && wr_ready) begin
            checksum <= checksum + (PROD_W + ADDR_W)'(wr_data);
        end
    end
`else
    // Without the checksum the write stream is not observed here.
`endif

endmodule

// File: tb/tb_times_table_writer.sv
// Self-checking bench for times_table_writer: cycle-exact vector table for
// the start of a fill, hand sequences for stall / restart / reset corners,
// and a randomized-ready fill checked against an 8x8 reference table.
module tb_times_table_writer;
    import times_table_writer_pkg::*;

    localparam int N = DEF_TABLE_SIZE;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       wr_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic       busy;
    logic       done;
`ifdef CHECKSUM_EN
    logic [11:0] checksum;
`endif

    always #5 clk = ~clk;

    times_table_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
`ifdef CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: the entry at address {a,b} holds a*b.
    function automatic int ref_product(input int addr);
        return (addr / (1 << DEF_OP_W)) * (addr % (1 << DEF_OP_W));
    endfunction

    // Memory model and write-stream observer, sampled mid-cycle.
    int         mem [N];
    int         writes      = 0;
    int         exp_next    = 0;
    int         done_pulses = 0;
    bit         done_prev   = 1'b0;
    bit         stall_prev  = 1'b0;
    logic [5:0] stall_addr;
    logic [5:0] stall_data;

    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            check("write_order", wr_addr, exp_next);
            check("write_data", wr_data, ref_product(int'(wr_addr)));
            mem[wr_addr] = int'(wr_data);
            writes++;
            exp_next++;
        end
        if (stall_prev) begin
            check("stall_hold_en", wr_en, 1);
            check("stall_hold_addr", wr_addr, stall_addr);
            check("stall_hold_data", wr_data, stall_data);
        end
        stall_prev = !rst && wr_en && !wr_ready;
        stall_addr = wr_addr;
        stall_data = wr_data;
        if (done) begin
            done_pulses++;
            check("done_width", done_prev, 0);
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic begin_fill();
        writes      = 0;
        exp_next    = 0;
        done_pulses = 0;
        for (int i = 0; i < N; i++) mem[i] = -1;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic wait_addr(input int addr, input int budget);
        int n = 0;
        while (!(wr_en === 1'b1 && wr_addr == 6'(addr)) && n < budget) begin
            wr_ready = 1'b1;
            tick();
            n++;
        end
        check("reach_addr", {wr_en, wr_addr}, {1'b1, 6'(addr)});
    endtask

    typedef struct {
        bit ready;
        bit en;
        int addr;
        int data;
        bit busy;
        bit done;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Cycle-by-cycle view after start is sampled, wr_ready per row.
        vecs[0]  = '{1, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 0, 0, 1, 0};
        vecs[3]  = '{1, 1, 0, 0, 1, 0};
        vecs[4]  = '{1, 0, 0, 0, 1, 0};
        vecs[5]  = '{1, 0, 0, 0, 1, 0};
        vecs[6]  = '{1, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 0, 1, 0};
        vecs[8]  = '{1, 1, 1, 0, 1, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 0, 0, 0, 1, 0};
        vecs[11] = '{1, 0, 0, 0, 1, 0};
        vecs[12] = '{1, 1, 2, 0, 1, 0};

        rst      = 1'b1;
        start    = 1'b0;
        wr_ready = 1'b0;
        begin_fill();
        tick();
        tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Fill 1: vector table for the first entries, then run to done.
        do_start();
        foreach (vecs[i]) begin
            wr_ready = vecs[i].ready;
            check($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].en);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
            if (vecs[i].en) begin
                check($sformatf("vec%0d_addr", i), wr_addr, vecs[i].addr);
                check($sformatf("vec%0d_data", i), wr_data, vecs[i].data);
            end
            tick();
        end
        wait_done(1000, 1'b0);
        check("fill1_writes", writes, 64);
        check("fill1_busy_at_done", busy, 0);
        check("fill1_en_at_done", wr_en, 0);
`ifdef CHECKSUM_EN
        check("fill1_checksum", checksum, 784);
`endif
        // start during the done cycle must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_busy", busy, 0);
        check("start_in_done_en", wr_en, 0);
        check("start_in_done_done", done, 0);
        check("fill1_done_pulses", done_pulses, 1);
        tick();
        check("still_idle", busy, 0);
`ifdef CHECKSUM_EN
        check("checksum_holds", checksum, 784);
`endif

        // Fill 2: 10-cycle stall on address 13, ignored start on address 20.
        begin_fill();
        do_start();
`ifdef CHECKSUM_EN
        check("checksum_cleared", checksum, 0);
`endif
        wait_addr(13, 200);
        wr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall13_en", wr_en, 1);
            check("stall13_addr", wr_addr, 13);
            check("stall13_data", wr_data, 5);
            tick();
        end
        wr_ready = 1'b1;
        tick();
        check("deassert_after_accept", wr_en, 0);
        check("writes_after_13", writes, 14);
        wait_addr(20, 200);
        start    = 1'b1;
        wr_ready = 1'b0;
        tick();
        start = 1'b0;
        check("busy_start_ignored_busy", busy, 1);
        check("busy_start_ignored_addr", {wr_en, wr_addr}, {1'b1, 6'd20});
        wait_done(1000, 1'b0);
        check("fill2_writes", writes, 64);
`ifdef CHECKSUM_EN
        check("fill2_checksum", checksum, 784);
`endif
        tick();

        // Fill 3: reset during the address-30 write, then a clean restart.
        begin_fill();
        do_start();
        wait_addr(30, 300);
        wr_ready = 1'b0;
        rst      = 1'b1;
        tick();
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_writes", writes, 30);
        rst = 1'b0;
        tick();
        check("midrst_idle", busy, 0);
        check("midrst_no_done", done_pulses, 0);
        begin_fill();
        do_start();
        wait_done(1000, 1'b0);
        check("fill3_writes", writes, 64);
        tick();

        // Fill 4: random wr_ready, memory compared with the reference table.
        begin_fill();
        do_start();
        wait_done(3000, 1'b1);
        tick();
        check("fill4_done_low", done, 0);
        check("fill4_done_pulses", done_pulses, 1);
        check("fill4_writes", writes, 64);
        for (int i = 0; i < N; i++) begin
            check($sformatf("table[%0d]", i), mem[i], ref_product(i));
        end
`ifdef CHECKSUM_EN
        check("fill4_checksum", checksum, 784);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
